// File: rtl/counter_sched_if.sv
// counter_sched_if: requester/counter bus for counter_sched.
// Requester side (master) drives req, req_data and req_len. Scheduler side
// (slave) returns gnt/done/abort/busy and drives the shared counter's
// load/data_in/enb through cnt_load/cnt_data/cnt_enb.
interface counter_sched_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned RUNW  = 8
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ*RUNW-1:0]  req_len;
  logic [NREQ-1:0]       gnt;
  logic                  done;
  logic                  abort;
  logic                  busy;
  logic                  cnt_load;
  logic [WIDTH-1:0]      cnt_data;
  logic                  cnt_enb;

  modport master (
    output req, req_data, req_len,
    input  gnt, done, abort, busy, cnt_load, cnt_data, cnt_enb
  );

  modport slave (
    input  req, req_data, req_len,
    output gnt, done, abort, busy, cnt_load, cnt_data, cnt_enb
  );
endinterface

// File: rtl/counter_sched.sv
// counter_sched: round-robin scheduler sharing one up/down counter between
// NREQ requesters. A job loads the counter with the winner's start value, then
// enables it for the winner's run length, then pulses done.
//
// Ports:
//   clk      - rising-edge clock
//   syn_rst  - synchronous active-high reset
//   bus      - counter_sched_if.slave: req/req_data/req_len in,
//              gnt/done/abort/busy/cnt_load/cnt_data/cnt_enb out (all registered)
//
// Optional feature: define COUNTER_SCHED_ABORT_EN to end a job early when the
// granted requester drops req during LOAD or RUN (done and abort pulse together).
// Without it abort is tied low and every job runs its full length.
module counter_sched #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned RUNW  = 8
) (
  input logic            clk,
  input logic            syn_rst,
  counter_sched_if.slave bus
);

  localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  logic [PTRW-1:0]   r_ptr;
  logic [PTRW-1:0]   r_win;
  logic [RUNW-1:0]   r_remain;
  logic [NREQ-1:0]   r_gnt;
  logic              r_done;
  logic              r_busy;
  logic              r_cnt_load;
  logic [WIDTH-1:0]  r_cnt_data;
  logic              r_cnt_enb;
`ifdef COUNTER_SCHED_ABORT_EN
  logic              r_abort;
  logic              w_req_win;
`endif

  logic              w_any;
  logic [PTRW-1:0]   w_win;
  logic [PTRW-1:0]   w_idx;
  logic [WIDTH-1:0]  w_data;
  logic [RUNW-1:0]   w_len;
  logic [PTRW-1:0]   w_ptr_next;

  // Round-robin pick: first set req bit at or after r_ptr, wrapping; plus the
  // winner's start value and run length.
  always_comb begin : arbiter
    w_any  = 1'b0;
    w_win  = r_ptr;
    w_idx  = '0;
    w_data = '0;
    w_len  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = PTRW'((32'(r_ptr) + k) % NREQ);
      if (!w_any && bus.req[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (w_win == PTRW'(k)) begin
        w_data = bus.req_data[k*WIDTH +: WIDTH];
        w_len  = bus.req_len[k*RUNW +: RUNW];
      end
    end
  end

  // Pointer moves just past the requester that was served.
  assign w_ptr_next = (r_win == PTRW'(NREQ - 1)) ? '0 : r_win + PTRW'(1);

`ifdef COUNTER_SCHED_ABORT_EN
  assign w_req_win = bus.req[r_win];
`endif

  // Job sequencer: IDLE -> LOAD -> RUN (len cycles, skipped for len 0) -> DONE.
  // r_remain is loaded with the run length in IDLE and counts down in RUN.
  always_ff @(posedge clk) begin
    if (syn_rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_win      <= '0;
      r_remain   <= '0;
      r_gnt      <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_cnt_load <= 1'b0;
      r_cnt_data <= '0;
      r_cnt_enb  <= 1'b0;
`ifdef COUNTER_SCHED_ABORT_EN
      r_abort    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state    <= S_LOAD;
            r_win      <= w_win;
            r_gnt      <= NREQ'(1) << w_win;
            r_busy     <= 1'b1;
            r_cnt_load <= 1'b1;
            r_cnt_data <= w_data;
            r_remain   <= w_len;
          end
        end
        S_LOAD: begin
          r_cnt_load <= 1'b0;
`ifdef COUNTER_SCHED_ABORT_EN
          if (!w_req_win) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_abort <= 1'b1;
          end else
`endif
          if (r_remain != '0) begin
            r_state   <= S_RUN;
            r_cnt_enb <= 1'b1;
          end else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_RUN: begin
`ifdef COUNTER_SCHED_ABORT_EN
          if (!w_req_win) begin
            r_state   <= S_DONE;
            r_cnt_enb <= 1'b0;
            r_done    <= 1'b1;
            r_abort   <= 1'b1;
          end else
`endif
          if (r_remain == RUNW'(1)) begin
            r_state   <= S_DONE;
            r_cnt_enb <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_remain <= r_remain - RUNW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_ptr   <= w_ptr_next;
`ifdef COUNTER_SCHED_ABORT_EN
          r_abort <= 1'b0;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.done     = r_done;
  assign bus.busy     = r_busy;
  assign bus.cnt_load = r_cnt_load;
  assign bus.cnt_data = r_cnt_data;
  assign bus.cnt_enb  = r_cnt_enb;
`ifdef COUNTER_SCHED_ABORT_EN
  assign bus.abort    = r_abort;
`else
  assign bus.abort    = 1'b0;
`endif

endmodule

// File: tb/tb_counter_sched.sv
// tb_counter_sched: self-checking bench for counter_sched (WIDTH=4, NREQ=4,
// RUNW=8). Expected per-cycle outputs of a job are derived from its winner,
// start value and length; a simple up-counter stands in for the shared counter.
module tb_counter_sched;

  logic clk = 1'b0;
  logic syn_rst = 1'b1;
  logic [3:0] cnt = 4'h0;

  int n_checks = 0;
  int n_err    = 0;
  int m_ptr    = 0;
  logic [3:0] m_last = 4'h0;

  counter_sched_if #(.WIDTH(4), .NREQ(4), .RUNW(8)) bus ();

  counter_sched #(.WIDTH(4), .NREQ(4), .RUNW(8)) dut (
    .clk     (clk),
    .syn_rst (syn_rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared counter (counting up); never reset by the scheduler.
  always @(posedge clk) begin
    if (bus.cnt_load === 1'b1)     cnt <= bus.cnt_data;
    else if (bus.cnt_enb === 1'b1) cnt <= cnt + 4'd1;
  end

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] data;
    logic [31:0] lens;
    int          exp_win;
    logic [3:0]  exp_data;
    int          exp_len;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [12:0] pack(input logic [3:0] g, input logic d,
                                       input logic ab, input logic b,
                                       input logic ld, input logic en,
                                       input logic [3:0] dat);
    return {g, d, ab, b, ld, en, dat};
  endfunction

  function automatic logic [12:0] obs();
    return {bus.gnt, bus.done, bus.abort, bus.busy, bus.cnt_load, bus.cnt_enb, bus.cnt_data};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Round-robin reference: first requesting index at or after ptr, wrapping.
  function automatic int rr_pick(input logic [3:0] mask, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (mask[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic scramble(input int win);
    logic [3:0] r;
    r = 4'($urandom);
    r[win] = bus.req[win];
    bus.req      = r;
    bus.req_data = 16'($urandom);
    bus.req_len  = $urandom;
  endtask

  task automatic do_reset();
    bus.req = 4'b0000;
    syn_rst = 1'b1;
    repeat (2) @(negedge clk);
    syn_rst = 1'b0;
    m_ptr  = 0;
    m_last = 4'h0;
    check("reset outputs", 32'(obs()), 32'h0);
  endtask

  // Called at a negedge while idle with inputs already set; the next posedge
  // samples them. drop_at >= 0 drops the winner's req at that job offset
  // (0 = LOAD cycle, k = k-th RUN cycle). Returns at the negedge of the
  // following idle cycle.
  task automatic run_job(input int win, input logic [3:0] data, input int len,
                         input int drop_at, input bit scr, input string name);
    int eff;
    logic ab;
    logic [3:0] g;
    logic [12:0] exp;
    g   = 4'(1) << win;
    eff = len;
    ab  = 1'b0;
`ifdef COUNTER_SCHED_ABORT_EN
    if (drop_at >= 0 && drop_at < len) begin
      eff = drop_at;
      ab  = 1'b1;
    end
`endif
    @(posedge clk);
    for (int c = 0; c <= eff + 1; c++) begin
      @(negedge clk);
      if (c == 0)        exp = pack(g, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, data);
      else if (c <= eff) exp = pack(g, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, data);
      else               exp = pack(g, 1'b1, ab,   1'b1, 1'b0, 1'b0, data);
      check($sformatf("%s cyc%0d", name, c), 32'(exp) ^ 32'(obs()) ^ 32'(exp), 32'(exp));
      if (c == eff + 1) check($sformatf("%s counter", name), 32'(cnt), 32'(4'(data + 4'(eff))));
      if (scr) scramble(win);
      if (c == drop_at) bus.req[win] = 1'b0;
    end
    @(negedge clk);
    check($sformatf("%s idle", name), 32'(obs()), 32'(pack(4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, data)));
    m_ptr  = (win + 1) % 4;
    m_last = data;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0]  mask;
    logic [15:0] rd;
    logic [31:0] rl;
    int          w;

    tbl[0] = '{4'b0110, 16'hA5C3, 32'h02000301, 1, 4'hC, 3};
    tbl[1] = '{4'b0011, 16'hA5C3, 32'h02000301, 0, 4'h3, 1};
    tbl[2] = '{4'b1001, 16'hA5C3, 32'h02000301, 3, 4'hA, 2};
    tbl[3] = '{4'b1111, 16'hA5C3, 32'h02000301, 0, 4'h3, 1};
    tbl[4] = '{4'b0001, 16'hA5C3, 32'h02000301, 0, 4'h3, 1};
    tbl[5] = '{4'b0100, 16'hA5C3, 32'h02000301, 2, 4'h5, 0};
    tbl[6] = '{4'b1100, 16'hA5C3, 32'h02000301, 3, 4'hA, 2};

    bus.req      = 4'b0000;
    bus.req_data = 16'h0;
    bus.req_len  = 32'h0;
    do_reset();

    // Basic job: start 3, length 5; counter ends at 8.
    bus.req = 4'b0001; bus.req_data = 16'h0003; bus.req_len = 32'd5;
    run_job(0, 4'h3, 5, -1, 1'b0, "basic");

    // Reset during RUN; ptr (1 before) must return to 0.
    bus.req = 4'b0001; bus.req_data = 16'h0009; bus.req_len = 32'd10;
    @(posedge clk);
    @(negedge clk);
    check("rstjob load", 32'(obs()), 32'(pack(4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h9)));
    repeat (3) @(negedge clk);
    check("rstjob run", 32'(obs()), 32'(pack(4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h9)));
    syn_rst = 1'b1;
    bus.req = 4'b0011; bus.req_data = 16'h0002; bus.req_len = 32'h0000_0001;
    @(negedge clk);
    check("rstjob outputs", 32'(obs()), 32'h0);
    syn_rst = 1'b0; m_ptr = 0; m_last = 4'h0;
    run_job(0, 4'h2, 1, -1, 1'b0, "after rst");

    // Round robin with all four requesting continuously.
    do_reset();
    bus.req = 4'b1111; bus.req_data = 16'h4321; bus.req_len = 32'h01010101;
    for (int k = 0; k < 5; k++)
      run_job(k % 4, 4'((k % 4) + 1), 1, -1, 1'b0, $sformatf("rr%0d", k));

    // Zero-length job on requester 2.
    bus.req = 4'b0100; bus.req_data = 16'h0E00; bus.req_len = 32'h0;
    run_job(2, 4'hE, 0, -1, 1'b0, "zero len");

    // Inputs changed mid-job must not affect the latched job.
    bus.req = 4'b1000; bus.req_data = 16'h5000; bus.req_len = 32'h04000000;
    run_job(3, 4'h5, 4, -1, 1'b1, "latch");

    // Requester 1 drops req after 3 RUN cycles (ptr is 0 here).
    bus.req = 4'b0010; bus.req_data = 16'h0070; bus.req_len = 32'h00001400;
    run_job(1, 4'h7, 20, 3, 1'b0, "drop run");

    // Requester 2 drops req during LOAD.
    bus.req = 4'b0100; bus.req_data = 16'h0100; bus.req_len = 32'h00050000;
    run_job(2, 4'h1, 5, 0, 1'b0, "drop load");

    // Table-driven arbitration vectors from a fresh pointer.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      bus.req = tbl[i].mask; bus.req_data = tbl[i].data; bus.req_len = tbl[i].lens;
      run_job(tbl[i].exp_win, tbl[i].exp_data, tbl[i].exp_len, -1, 1'b0, $sformatf("tbl%0d", i));
    end

    // Randomized jobs against the round-robin reference.
    for (int i = 0; i < 40; i++) begin
      mask = 4'($urandom);
      rd   = 16'($urandom);
      rl   = 32'($urandom) & 32'h07070707;
      bus.req = mask; bus.req_data = rd; bus.req_len = rl;
      if (mask == 4'b0) begin
        @(negedge clk);
        check($sformatf("rnd%0d idle", i), 32'(obs()),
              32'(pack(4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_last)));
      end else begin
        w = rr_pick(mask, m_ptr);
        run_job(w, rd[w*4 +: 4], int'(rl[w*8 +: 8]), -1, 1'($urandom), $sformatf("rnd%0d", i));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
